inc_dec_decoder: RTL and testbench

Observer for a stepped up/down-by-3 counter bus. Samples an n-bit count value on a strobe, compares it with the previously accepted sample and recovers the command that produced it: increment (+3), decrement (−3) or hold. Any other step is a protocol error. Sits on the receiving side of a counter's `out` bus, for monitoring, re-synchronisation and error accounting.

---
 rtl/inc_dec_decoder.sv | 127 ++++++++++++
 tb/tb_inc_dec_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inc_dec_decoder.sv
// inc_dec_decoder
// Receiving-side observer for a counter bus that moves in steps of +3 or -3.
// Each strobed sample is compared with the last accepted one to recover the
// command that produced it: increment, decrement, hold, or an illegal step.
// A run of ERR_LIMIT consecutive illegal steps drops lock, and the next
// sample then only re-establishes the reference.

module inc_dec_decoder #(
   parameter int n         = 8,   // count width, 3..32
   parameter int ERR_LIMIT = 4    // consecutive errors that force unlock, 1..255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] cnt_in,
   input  logic         sample,
   input  logic         clr_err,
   output logic         inc_out,
   output logic         dec_out,
   output logic         hold_out,
   output logic         err_out,
   output logic         locked,
   output logic [7:0]   err_cnt
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   // Legal step sizes as n-bit wrap-around differences.
   localparam logic [n-1:0] INC_STEP = n'(3);
   localparam logic [n-1:0] DEC_STEP = ~INC_STEP + {{(n-1){1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic [n-1:0]   prev_q, prev_d;
   logic [7:0]     run_q, run_d;
   logic [7:0]     err_cnt_q, err_cnt_d;
   logic           inc_q, inc_d;
   logic           dec_q, dec_d;
   logic           hold_q, hold_d;
   logic           err_q, err_d;

   logic [n-1:0]   diff;
   logic [8:0]     run_inc;

   assign diff    = cnt_in - prev_q;
   assign run_inc = {1'b0, run_q} + 9'd1;

   // Decode the step against the reference and compute next state and pulses.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      prev_d    = prev_q;
      run_d     = run_q;
      err_cnt_d = clr_err ? 8'd0 : err_cnt_q;   // clear applies before any increment
      inc_d     = 1'b0;
      dec_d     = 1'b0;
      hold_d    = 1'b0;
      err_d     = 1'b0;

      if (sample) begin
         if (state_q == UNLOCKED) begin
            // First sample only establishes the reference.
            prev_d  = cnt_in;
            run_d   = 8'd0;
            state_d = LOCKED;
         end else if (diff == INC_STEP) begin
            inc_d  = 1'b1;
            prev_d = cnt_in;
            run_d  = 8'd0;
         end else if (diff == DEC_STEP) begin
            dec_d  = 1'b1;
            prev_d = cnt_in;
            run_d  = 8'd0;
         end else if (diff == '0) begin
            hold_d = 1'b1;
            run_d  = 8'd0;
         end else begin
            // Illegal step: flag it and resynchronise on the new value.
            err_d  = 1'b1;
            prev_d = cnt_in;
            if (err_cnt_d != 8'hFF) begin
               err_cnt_d = err_cnt_d + 8'd1;
            end
            if (run_inc == 9'(ERR_LIMIT)) begin
               state_d = UNLOCKED;
               run_d   = 8'd0;
            end else begin
               run_d = run_inc[7:0];
            end
         end
      end
   end

   // State, reference and output registers; reset acts without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= UNLOCKED;
         prev_q    <= '0;
         run_q     <= 8'd0;
         err_cnt_q <= 8'd0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         hold_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         err_cnt_q <= err_cnt_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
      end
   end

   assign inc_out  = inc_q;
   assign dec_out  = dec_q;
   assign hold_out = hold_q;
   assign err_out  = err_q;
   assign locked   = (state_q == LOCKED);
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inc_dec_decoder.sv
// Testbench for inc_dec_decoder: directed vectors, expected responses queued
// by the driver and compared by an independent monitor one edge later.
// Two instances: ERR_LIMIT=4 for the main tests, ERR_LIMIT=255 for saturation.

module tb_inc_dec_decoder;

   localparam logic [3:0] P_NONE = 4'b0000;
   localparam logic [3:0] P_INC  = 4'b1000;
   localparam logic [3:0] P_DEC  = 4'b0100;
   localparam logic [3:0] P_HOLD = 4'b0010;
   localparam logic [3:0] P_ERR  = 4'b0001;

   typedef struct {
      bit         sel;      // 0: main instance, 1: saturation instance
      logic [3:0] pulses;   // {inc, dec, hold, err}
      logic       lk;
      logic [7:0] ec;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cnt_a = '0, cnt_b = '0;
   logic       smp_a = 1'b0, smp_b = 1'b0;
   logic       clr_a = 1'b0, clr_b = 1'b0;
   logic       inc_a, dec_a, hold_a, err_a, lk_a;
   logic       inc_b, dec_b, hold_b, err_b, lk_b;
   logic [7:0] ec_a, ec_b;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   inc_dec_decoder #(.n(8), .ERR_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_a), .sample(smp_a), .clr_err(clr_a),
      .inc_out(inc_a), .dec_out(dec_a), .hold_out(hold_a), .err_out(err_a),
      .locked(lk_a), .err_cnt(ec_a)
   );

   inc_dec_decoder #(.n(8), .ERR_LIMIT(255)) dut_sat (
      .clk(clk), .rst(rst), .cnt_in(cnt_b), .sample(smp_b), .clr_err(clr_b),
      .inc_out(inc_b), .dec_out(dec_b), .hold_out(hold_b), .err_out(err_b),
      .locked(lk_b), .err_cnt(ec_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares the selected instance's registered outputs after each edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (!e.sel)
            check(e.name, {19'd0, inc_a, dec_a, hold_a, err_a, lk_a, ec_a},
                  {19'd0, e.pulses, e.lk, e.ec});
         else
            check(e.name, {19'd0, inc_b, dec_b, hold_b, err_b, lk_b, ec_b},
                  {19'd0, e.pulses, e.lk, e.ec});
      end
   end

   // Drive one cycle of stimulus and queue the response expected after the edge.
   task automatic step(input bit sel, input logic [7:0] cnt, input bit smp,
                       input bit clr, input logic [3:0] pul, input bit lk,
                       input logic [7:0] ec, input string name);
      exp_t e;
      @(negedge clk);
      smp_a = 1'b0; smp_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      if (!sel) begin cnt_a = cnt; smp_a = smp; clr_a = clr; end
      else      begin cnt_b = cnt; smp_b = smp; clr_b = clr; end
      e.sel = sel; e.pulses = pul; e.lk = lk; e.ec = ec; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      smp_a = 1'b0; smp_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state, checked directly while reset is held.
      repeat (2) @(negedge clk);
      check("reset_state_a", {19'd0, inc_a, dec_a, hold_a, err_a, lk_a, ec_a}, 32'd0);
      check("reset_state_b", {19'd0, inc_b, dec_b, hold_b, err_b, lk_b, ec_b}, 32'd0);
      rst = 1'b0;

      // Lock and increment.
      step(0, 8'd10, 1, 0, P_NONE, 1, 8'd0, "lock_10");
      step(0, 8'd13, 1, 0, P_INC,  1, 8'd0, "inc_13");
      step(0, 8'd16, 1, 0, P_INC,  1, 8'd0, "inc_16");
      step(0, 8'd99, 0, 0, P_NONE, 1, 8'd0, "inc_pulse_ends");

      // Decrement across the wrap, then increment across the wrap.
      do_reset();
      step(0, 8'd1,   1, 0, P_NONE, 1, 8'd0, "lock_1");
      step(0, 8'd254, 1, 0, P_DEC,  1, 8'd0, "dec_wrap_1_254");
      do_reset();
      step(0, 8'd254, 1, 0, P_NONE, 1, 8'd0, "lock_254");
      step(0, 8'd1,   1, 0, P_INC,  1, 8'd0, "inc_wrap_254_1");

      // Hold and gaps; cnt_in changes while sample is low must be ignored.
      do_reset();
      step(0, 8'd40, 1, 0, P_NONE, 1, 8'd0, "lock_40");
      step(0, 8'd40, 1, 0, P_HOLD, 1, 8'd0, "hold_40");
      for (int i = 0; i < 5; i++)
         step(0, 8'(i * 17 + 5), 0, 0, P_NONE, 1, 8'd0, "gap_quiet");
      step(0, 8'd43, 1, 0, P_INC,  1, 8'd0, "inc_after_gap");

      // Errors and loss of lock at ERR_LIMIT=4.
      do_reset();
      step(0, 8'd0,  1, 0, P_NONE, 1, 8'd0, "lock_0");
      step(0, 8'd7,  1, 0, P_ERR,  1, 8'd1, "err_1");
      step(0, 8'd20, 1, 0, P_ERR,  1, 8'd2, "err_2");
      step(0, 8'd50, 1, 0, P_ERR,  1, 8'd3, "err_3");
      step(0, 8'd90, 1, 0, P_ERR,  0, 8'd4, "err_4_unlock");
      step(0, 8'd93, 1, 0, P_NONE, 1, 8'd4, "relock_93");
      // clr_err alone clears the count but leaves lock alone.
      step(0, 8'd96, 1, 1, P_INC,  1, 8'd0, "clr_with_inc");
      step(0, 8'd0,  0, 0, P_NONE, 1, 8'd0, "idle_after_clr");

      // Saturation with ERR_LIMIT=255: the 255th error drops lock.
      do_reset();
      step(1, 8'd0, 1, 0, P_NONE, 1, 8'd0, "sat_lock");
      for (int k = 1; k <= 301; k++) begin
         if (k < 255)
            step(1, 8'(k * 7), 1, 0, P_ERR,  1, 8'(k),  "sat_err_count");
         else if (k == 255)
            step(1, 8'(k * 7), 1, 0, P_ERR,  0, 8'd255, "sat_err_limit_unlock");
         else if (k == 256)
            step(1, 8'(k * 7), 1, 0, P_NONE, 1, 8'd255, "sat_relock");
         else
            step(1, 8'(k * 7), 1, 0, P_ERR,  1, 8'd255, "sat_hold_255");
      end
      step(1, 8'(302 * 7), 1, 1, P_ERR,  1, 8'd1, "clr_with_err");
      step(1, 8'd0,        0, 1, P_NONE, 1, 8'd0, "clr_alone");
      step(1, 8'd0,        0, 0, P_NONE, 1, 8'd0, "sat_idle");
      drain();

      // Asynchronous reset between edges while locked with err_cnt=3.
      do_reset();
      step(0, 8'd0,   1, 0, P_NONE, 1, 8'd0, "ar_lock");
      step(0, 8'd5,   1, 0, P_ERR,  1, 8'd1, "ar_err_1");
      step(0, 8'd100, 1, 0, P_ERR,  1, 8'd2, "ar_err_2");
      step(0, 8'd9,   1, 0, P_ERR,  1, 8'd3, "ar_err_3");
      @(posedge clk);
      #2;
      smp_a = 1'b0;
      rst = 1'b1;
      #1;
      check("async_reset_immediate",
            {19'd0, inc_a, dec_a, hold_a, err_a, lk_a, ec_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 8'd30, 1, 0, P_NONE, 1, 8'd0, "first_after_reset_locks");
      step(0, 8'd0,  0, 0, P_NONE, 1, 8'd0, "final_idle");
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
